serial_rx: RTL and testbench

Bit-serial frame receiver that forms the host end of the mini_bit `tx` line: it deserializes the frames the sequencer shifts out and presents them as bytes through a small FIFO with a valid/ready handshake. It sits beside the mini_bit top level in the host or test harness. Its own serial output companion drives the CPU's `rx` input; that companion is not part of this block.

---
 rtl/serial_defs.sv | 27 ++
 rtl/serial_rx_fifo.sv | 72 +++++++
 rtl/serial_rx.sv | 245 ++++++++++++++++++++++++
 tb/tb_serial_rx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_defs.sv
// serial_defs: definitions shared by the serial receiver and its future
// transmit companion.
//   - frame state encodings (3-bit) and the receiver state enum
//   - SERIAL_DATA_BITS  : data bits per frame
//   - SERIAL_IDLE_LEVEL : line level when no frame is in flight
package serial_defs;

  localparam int unsigned SERIAL_DATA_BITS  = 8;
  localparam logic        SERIAL_IDLE_LEVEL = 1'b1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_START     = ST_START,
    S_DATA      = ST_DATA,
    S_PARITY    = ST_PARITY,
    S_STOP      = ST_STOP,
    S_WAIT_IDLE = ST_WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: synchronous FIFO holding received bytes.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   push, data  : write request and payload (ignored when full)
//   pop         : read request (ignored when empty)
//   head        : registered head entry, meaningful while valid = 1
//   valid       : FIFO non-empty (registered)
//   full_c      : FIFO full, derived combinationally from the count register
//   count       : number of stored entries
module serial_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic                     full_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] count_next;
  logic             push_ok;
  logic             pop_ok;

  // Fullness is judged on the registered count, before any same-cycle pop.
  assign full_c     = (count == CNT_W'(DEPTH));
  assign push_ok    = push && !full_c;
  assign pop_ok     = pop && valid;
  assign rd_next    = pop_ok ? rd_ptr + PTR_W'(1) : rd_ptr;
  assign count_next = count + CNT_W'(push_ok) - CNT_W'(pop_ok);

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= data;
    end
  end

  // Pointers, count and the registered head view.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_ok);
      rd_ptr <= rd_next;
      count  <= count_next;
      valid  <= (count_next != '0);
      // Bypass when the byte being written becomes the new head.
      if (push_ok && (wr_ptr == rd_next)) begin
        head <= data;
      end else begin
        head <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/serial_rx.sv
// serial_rx: bit-serial frame receiver with a byte FIFO and valid/ready output.
// Frame: start 0, 8 data bits LSB first, optional even parity bit, stop 1.
// Optional parity is enabled by defining SERIAL_RX_PARITY_EN.
// Ports:
//   clk         : clock, rising edge
//   reg_clear   : asynchronous active-high reset
//   line_in     : serial line, idle high
//   data_out    : byte at the FIFO head
//   data_valid  : FIFO non-empty
//   data_ready  : consumer accepts the head byte
//   frame_err   : one-cycle pulse, stop bit sampled low
//   parity_err  : one-cycle pulse, parity mismatch (0 without parity)
//   overflow    : one-cycle pulse, good byte dropped on a full FIFO
//   busy        : receiver not idle
//   fifo_count  : FIFO occupancy
module serial_rx
  import serial_defs::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reg_clear,
  input  logic                          line_in,
  output logic [SERIAL_DATA_BITS-1:0]   data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(SERIAL_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(SERIAL_DATA_BITS - 1);

  // Synchronizer and edge detection.
  logic sync_meta;
  logic line;
  logic line_prev;
  logic fall_c;

  rx_state_e                   state;
  rx_state_e                   state_next;
  logic [CNT_W-1:0]            cnt;
  logic [CNT_W-1:0]            cnt_next;
  logic                        cnt_zero;
  logic [BIT_W-1:0]            bit_idx;
  logic [BIT_W-1:0]            bit_next;
  logic [SERIAL_DATA_BITS-1:0] shift;
  logic [SERIAL_DATA_BITS-1:0] shift_next;
  logic                        frame_err_next;
  logic                        overflow_next;
  logic                        busy_next;
  logic                        par_bad;
`ifdef SERIAL_RX_PARITY_EN
  logic                        par_bad_next;
  logic                        parity_err_next;
`endif

  logic                        push_c;
  logic                        fifo_full_c;

  // Two-flop synchronizer plus one history flop; idles at the line idle level.
  always_ff @(posedge clk or posedge reg_clear) begin
    if (reg_clear) begin
      sync_meta <= SERIAL_IDLE_LEVEL;
      line      <= SERIAL_IDLE_LEVEL;
      line_prev <= SERIAL_IDLE_LEVEL;
    end else begin
      sync_meta <= line_in;
      line      <= sync_meta;
      line_prev <= line;
    end
  end

  assign fall_c   = (line_prev == SERIAL_IDLE_LEVEL) && (line != SERIAL_IDLE_LEVEL);
  assign cnt_zero = (cnt == '0);

  // Next-state and registered-output logic for the frame FSM.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    bit_next       = bit_idx;
    shift_next     = shift;
    frame_err_next = 1'b0;
    overflow_next  = 1'b0;
    push_c         = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_bad_next    = par_bad;
    parity_err_next = 1'b0;
`endif

    unique case (state)
      S_IDLE: begin
        if (fall_c) begin
          state_next = S_START;
          cnt_next   = HALF_LOAD;
        end
      end

      S_START: begin
        if (!cnt_zero) begin
          cnt_next = cnt - CNT_W'(1);
        end else if (line != SERIAL_IDLE_LEVEL) begin
          state_next = S_DATA;
          cnt_next   = FULL_LOAD;
          bit_next   = '0;
`ifdef SERIAL_RX_PARITY_EN
          par_bad_next = 1'b0;
`endif
        end else begin
          // False start: line back high at mid start bit.
          state_next = S_IDLE;
        end
      end

      S_DATA: begin
        if (!cnt_zero) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          shift_next = {line, shift[SERIAL_DATA_BITS-1:1]};
          cnt_next   = FULL_LOAD;
          if (bit_idx == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end else begin
            bit_next = bit_idx + BIT_W'(1);
          end
        end
      end

`ifdef SERIAL_RX_PARITY_EN
      S_PARITY: begin
        if (!cnt_zero) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          // Even parity: the parity bit equals the XOR of the data bits.
          par_bad_next = line ^ (^shift);
          cnt_next     = FULL_LOAD;
          state_next   = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (!cnt_zero) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
`ifdef SERIAL_RX_PARITY_EN
          parity_err_next = par_bad;
`endif
          if (line == SERIAL_IDLE_LEVEL) begin
            if (!par_bad) begin
              if (fifo_full_c) begin
                overflow_next = 1'b1;
              end else begin
                push_c = 1'b1;
              end
            end
            state_next = S_IDLE;
          end else begin
            // Stop bit low: hold off until the line idles so a break is not
            // taken as a train of frames.
            frame_err_next = 1'b1;
            state_next     = S_WAIT_IDLE;
          end
        end
      end

      S_WAIT_IDLE: begin
        if (line == SERIAL_IDLE_LEVEL) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    busy_next = (state_next != S_IDLE);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge reg_clear) begin
    if (reg_clear) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bit_idx   <= bit_next;
      shift     <= shift_next;
      frame_err <= frame_err_next;
      overflow  <= overflow_next;
      busy      <= busy_next;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  // Parity check result and its error pulse.
  always_ff @(posedge clk or posedge reg_clear) begin
    if (reg_clear) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad    <= par_bad_next;
      parity_err <= parity_err_next;
    end
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Received-byte queue; pops only when non-empty.
  serial_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SERIAL_DATA_BITS)
  ) u_fifo (
    .clk    (clk),
    .rst    (reg_clear),
    .push   (push_c),
    .data   (shift),
    .pop    (data_ready),
    .head   (data_out),
    .valid  (data_valid),
    .full_c (fifo_full_c),
    .count  (fifo_count)
  );

endmodule

// File: tb/tb_serial_rx.sv
module tb_serial_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef SERIAL_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       reg_clear;
  logic       line_in;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overflow;
  logic       busy;
  logic [2:0] fifo_count;

  serial_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reg_clear  (reg_clear),
    .line_in    (line_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overflow   (overflow),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Output monitor: pulse counts, high-cycle counts, popped bytes, first valid rise.
  int ferr_n = 0, perr_n = 0, ovf_n = 0;
  int ferr_hi = 0, perr_hi = 0, ovf_hi = 0;
  logic ferr_q = 0, perr_q = 0, ovf_q = 0, dv_q = 0;
  int rise_cyc = -1;
  logic [7:0] popped[$];

  always @(negedge clk) begin
    if (!reg_clear) begin
      if (frame_err)  begin ferr_hi++; if (!ferr_q) ferr_n++; end
      if (parity_err) begin perr_hi++; if (!perr_q) perr_n++; end
      if (overflow)   begin ovf_hi++;  if (!ovf_q)  ovf_n++;  end
      if (data_valid && data_ready) popped.push_back(data_out);
      if (data_valid && !dv_q && rise_cyc < 0) rise_cyc = cyc;
    end
    ferr_q = frame_err;
    perr_q = parity_err;
    ovf_q  = overflow;
    dv_q   = data_valid;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    line_in = 1'b1;
    repeat (n) step();
  endtask

  task automatic drive_bit(input logic v, input int n);
    line_in = v;
    repeat (n) step();
  endtask

  int last_start;

  // One frame; a low stop bit is held low for extra_low further cycles.
  task automatic send_frame(input logic [7:0] d, input bit bad_par,
                            input bit stop_low, input int extra_low);
    last_start = cyc;
    drive_bit(1'b0, CPB);
    for (int b = 0; b < 8; b++) drive_bit(d[b], CPB);
    if (PAR != 0) drive_bit((^d) ^ bad_par, CPB);
    if (stop_low) drive_bit(1'b0, CPB + extra_low);
    else          drive_bit(1'b1, CPB);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit         stop_low;
    bit         exp_byte;
    int         exp_ferr;
    int         exp_perr;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int k, f0, ferr0, perr0, ovf0, exp_ovf, ef, ep, n;
    logic [7:0] d;

    vecs.push_back('{8'hA5, 1'b0, 1'b0, 1'b1, 0, 0});
    vecs.push_back('{8'h3C, 1'b0, 1'b1, 1'b0, 1, 0});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 1'b1, 0, 0});
    vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b1, 0, 0});
    vecs.push_back('{8'h80, 1'b0, 1'b0, 1'b1, 0, 0});
`ifdef SERIAL_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b0, 1'b0, 0, 1});
    vecs.push_back('{8'h07, 1'b0, 1'b0, 1'b1, 0, 0});
    vecs.push_back('{8'h5A, 1'b1, 1'b1, 1'b0, 1, 1});
`endif

    // Reset values
    reg_clear  = 1'b1;
    line_in    = 1'b1;
    data_ready = 1'b0;
    repeat (3) step();
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_flags", {frame_err, parity_err, overflow}, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    reg_clear = 1'b0;
    idle(5);
    check("idle_busy", busy, 0);

    // Single frame latency: valid rises one cycle after the stop sample.
    rise_cyc = -1;
    send_frame(8'hA5, 1'b0, 1'b0, 0);
    k = last_start;
    idle(20);
    check("a5_valid_rise_cycle", rise_cyc, k + 2 + CPB/2 + (9 + PAR)*CPB + 1);
    check("a5_data_out", data_out, 8'hA5);
    check("a5_fifo_count", fifo_count, 1);
    data_ready = 1'b1;
    idle(3);
    check("a5_pop_size", popped.size(), 1);
    check("a5_pop_value", popped[0], 8'hA5);
    check("a5_empty_after_pop", fifo_count, 0);
    popped.delete();

    // Glitch of 6 cycles: false start, back to idle with no flags.
    f0 = ferr_n + perr_n + ovf_n;
    line_in = 1'b0;
    k = cyc;
    repeat (6) step();
    line_in = 1'b1;
    check("glitch_busy_in_start", busy, 1);
    repeat (6) step();
    check("glitch_back_idle", busy, 0);
    check("glitch_no_flags", ferr_n + perr_n + ovf_n - f0, 0);
    check("glitch_fifo_empty", fifo_count, 0);
    idle(10);

    // Stop bit low with line held low 40 more cycles.
    ferr0 = ferr_n;
    send_frame(8'h3C, 1'b0, 1'b1, 40);
    check("ferr_busy_while_low", busy, 1);
    line_in = 1'b1;
    step();
    step();
    check("ferr_busy_sync_delay", busy, 1);
    step();
    check("ferr_busy_released", busy, 0);
    check("ferr_pulse_count", ferr_n - ferr0, 1);
    check("ferr_fifo_empty", fifo_count, 0);
    check("ferr_no_byte", popped.size(), 0);
    idle(5);

    // Table vectors with the consumer always ready.
    foreach (vecs[i]) begin
      ferr0 = ferr_n;
      perr0 = perr_n;
      popped.delete();
      send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].stop_low, vecs[i].stop_low ? 10 : 0);
      idle(20);
      check($sformatf("vec%0d_ferr", i), ferr_n - ferr0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_perr", i), perr_n - perr0, vecs[i].exp_perr);
      check($sformatf("vec%0d_bytes", i), popped.size(), int'(vecs[i].exp_byte));
      if (vecs[i].exp_byte && popped.size() > 0)
        check($sformatf("vec%0d_data", i), popped[0], vecs[i].data);
    end

    // Six back-to-back frames with no consumer: FIFO fills then overflows.
    data_ready = 1'b0;
    popped.delete();
    exp_q.delete();
    exp_ovf = 0;
    ovf0 = ovf_n;
    for (int i = 1; i <= 6; i++) begin
      send_frame(8'(i), 1'b0, 1'b0, 0);
      if (exp_q.size() < DEPTH) exp_q.push_back(8'(i));
      else exp_ovf++;
    end
    idle(20);
    check("b2b_fifo_count", fifo_count, exp_q.size());
    check("b2b_overflow_pulses", ovf_n - ovf0, exp_ovf);
    check("b2b_head", data_out, exp_q[0]);
    data_ready = 1'b1;
    idle(10);
    check("b2b_pop_count", popped.size(), exp_q.size());
    for (int i = 0; i < popped.size() && i < exp_q.size(); i++)
      check($sformatf("b2b_pop%0d", i), popped[i], exp_q[i]);
    check("b2b_drained", fifo_count, 0);

    // Reset in the middle of data bit 3 with two bytes queued.
    data_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 0);
    send_frame(8'h22, 1'b0, 1'b0, 0);
    idle(5);
    check("midrst_queued", fifo_count, 2);
    d = 8'h77;
    drive_bit(1'b0, CPB);
    for (int b = 0; b < 3; b++) drive_bit(d[b], CPB);
    line_in = d[3];
    repeat (CPB/2) step();
    check("midrst_busy_before", busy, 1);
    reg_clear = 1'b1;
    #1;
    check("midrst_data_valid", data_valid, 0);
    check("midrst_fifo_count", fifo_count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_data_out", data_out, 0);
    check("midrst_flags", {frame_err, parity_err, overflow}, 0);
    line_in = 1'b1;
    step();
    step();
    reg_clear = 1'b0;
    idle(10);
    check("midrst_idle_after_release", busy, 0);
    popped.delete();
    data_ready = 1'b1;
    send_frame(8'h55, 1'b0, 1'b0, 0);
    idle(20);
    check("midrst_next_count", popped.size(), 1);
    check("midrst_next_data", popped[0], 8'h55);

    // Randomized frames against the frame-level reference model.
    popped.delete();
    exp_q.delete();
    ferr0 = ferr_n;
    perr0 = perr_n;
    ovf0  = ovf_n;
    ef = 0;
    ep = 0;
    for (int t = 0; t < 40; t++) begin
      bit sl, bp;
      d  = 8'($urandom);
      n  = int'($urandom_range(0, 9));
      sl = (n == 0);
      bp = (PAR != 0) && (n == 1 || n == 2);
      send_frame(d, bp, sl, sl ? int'($urandom_range(0, 20)) : 0);
      if (sl) ef++;
      if (bp) ep++;
      if (!sl && !bp) exp_q.push_back(d);
      idle(sl ? int'($urandom_range(4, 10)) : int'($urandom_range(0, 3)));
    end
    idle(30);
    check("rand_byte_count", popped.size(), exp_q.size());
    for (int i = 0; i < popped.size() && i < exp_q.size(); i++)
      check($sformatf("rand_byte%0d", i), popped[i], exp_q[i]);
    check("rand_ferr", ferr_n - ferr0, ef);
    check("rand_perr", perr_n - perr0, ep);
    check("rand_no_overflow", ovf_n - ovf0, 0);

    // Every flag pulse lasts exactly one cycle.
    check("pulse_width", ferr_hi + perr_hi + ovf_hi, ferr_n + perr_n + ovf_n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
